// File: rtl/urv_irq_controller.sv
// External interrupt controller: synchronizes, latches and masks N_SRC sources,
// presents the lowest-index winner one-hot, and handles claim/complete over a register port.
module urv_irq_controller #(
  parameter int unsigned N_SRC       = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_SRC-1:0] irq_src_i,
  input  logic [2:0]       reg_sel_i,
  input  logic             reg_we_i,
  input  logic             reg_re_i,
  input  logic [31:0]      reg_wdata_i,
  output logic [31:0]      reg_rdata_o,
  output logic [31:0]      irq_o,
  output logic             irq_active_o
);

  localparam int unsigned IdW = 5;

  localparam logic [2:0] SelEnable   = 3'd0;
  localparam logic [2:0] SelEdge     = 3'd1;
  localparam logic [2:0] SelPending  = 3'd2;
  localparam logic [2:0] SelClaim    = 3'd3;
  localparam logic [2:0] SelComplete = 3'd4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PEND    = 2'd1,
    SERVICE = 2'd2
  } state_e;

  logic [N_SRC-1:0] sync_q [SYNC_STAGES];
  logic [N_SRC-1:0] sync_prev_q;
  logic [N_SRC-1:0] enable_q;
  logic [N_SRC-1:0] edge_q;
  logic [N_SRC-1:0] pend_q;
  logic [N_SRC-1:0] pend_d;

  logic [N_SRC-1:0] sync_w;
  logic [N_SRC-1:0] rise_w;
  logic [N_SRC-1:0] pending_w;
  logic [N_SRC-1:0] cand_w;
  logic [N_SRC-1:0] w1c_w;
  logic [N_SRC-1:0] claim_clr_w;
  logic [31:0]      cand_ext_w;

  state_e          state_q;
  logic [IdW-1:0]  cur_id_q;
  logic [31:0]     irq_q;
  logic            active_q;
  logic [31:0]     rdata_q;
  logic [31:0]     rdata_d;

  logic [IdW-1:0]  win_id_w;
  logic [5:0]      cur_num_w;
  logic            cur_hit_w;
  logic            claim_val_w;
  logic            claim_rd_w;
  logic            complete_ok_w;
  logic            unused_w;

  assign unused_w = ^reg_wdata_i;

  // Input synchronizer plus one extra flop of history for edge detection
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int s = 0; s < int'(SYNC_STAGES); s++) sync_q[s] <= '0;
      sync_prev_q <= '0;
    end else begin
      sync_q[0] <= irq_src_i;
      for (int s = 1; s < int'(SYNC_STAGES); s++) sync_q[s] <= sync_q[s-1];
      sync_prev_q <= sync_w;
    end
  end

  assign sync_w     = sync_q[SYNC_STAGES-1];
  // Rises are only captured while a source is configured edge-triggered
  assign rise_w     = sync_w & ~sync_prev_q & edge_q;
  assign pending_w  = (edge_q & pend_q) | (~edge_q & sync_w);
  assign cand_w     = pending_w & enable_q;
  assign cand_ext_w = 32'(cand_w);

  always_comb begin
    win_id_w = '0;
    for (int i = int'(N_SRC) - 1; i >= 0; i--) begin
      if (cand_w[i]) win_id_w = IdW'(i);
    end
  end

  assign cur_num_w     = 6'(cur_id_q) + 6'd1;
  assign cur_hit_w     = cand_ext_w[cur_id_q];
  assign claim_val_w   = (state_q == PEND) && cur_hit_w;
  assign claim_rd_w    = reg_re_i && (reg_sel_i == SelClaim);
  assign complete_ok_w = reg_we_i && (reg_sel_i == SelComplete) &&
                         (reg_wdata_i[5:0] == cur_num_w);

  assign w1c_w       = (reg_we_i && (reg_sel_i == SelPending)) ? reg_wdata_i[N_SRC-1:0] : '0;
  assign claim_clr_w = (claim_val_w && claim_rd_w) ?
                       (N_SRC'(32'd1 << cur_id_q) & edge_q) : '0;
  // A set landing together with a clear wins
  assign pend_d      = (pend_q & ~(w1c_w | claim_clr_w)) | rise_w;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      enable_q <= '0;
      edge_q   <= '0;
      pend_q   <= '0;
    end else begin
      if (reg_we_i && (reg_sel_i == SelEnable)) enable_q <= reg_wdata_i[N_SRC-1:0];
      if (reg_we_i && (reg_sel_i == SelEdge))   edge_q   <= reg_wdata_i[N_SRC-1:0];
      pend_q <= pend_d;
    end
  end

  always_comb begin
    rdata_d = '0;
    case (reg_sel_i)
      SelEnable:  rdata_d = 32'(enable_q);
      SelEdge:    rdata_d = 32'(edge_q);
      SelPending: rdata_d = 32'(pending_w);
      SelClaim:   rdata_d = claim_val_w ? 32'(cur_num_w) : 32'd0;
      default:    rdata_d = '0;
    endcase
  end

  // Claim/complete FSM with registered irq, active and read-data outputs
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      cur_id_q <= '0;
      irq_q    <= '0;
      active_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      if (reg_re_i) rdata_q <= rdata_d;
      case (state_q)
        IDLE: begin
          if (|cand_w) begin
            state_q  <= PEND;
            cur_id_q <= win_id_w;
            irq_q    <= 32'd1 << win_id_w;
            active_q <= 1'b1;
          end
        end
        PEND: begin
          if (!cur_hit_w) begin
            state_q  <= IDLE;
            irq_q    <= '0;
            active_q <= 1'b0;
          end else if (claim_rd_w) begin
            state_q <= SERVICE;
            irq_q   <= '0;
          end
        end
        SERVICE: begin
          if (complete_ok_w) begin
            state_q  <= IDLE;
            active_q <= 1'b0;
          end
        end
        default: begin
          state_q  <= IDLE;
          irq_q    <= '0;
          active_q <= 1'b0;
        end
      endcase
    end
  end

  assign reg_rdata_o  = rdata_q;
  assign irq_o        = irq_q;
  assign irq_active_o = active_q;

endmodule

// File: tb/tb_urv_irq_controller.sv
// Bench for urv_irq_controller: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the controller.
module tb_urv_irq_controller;

  localparam int unsigned N_SRC       = 32;
  localparam int unsigned SYNC_STAGES = 2;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic [31:0] irq_src_i = '0;
  logic [2:0]  reg_sel_i = '0;
  logic        reg_we_i = 1'b0;
  logic        reg_re_i = 1'b0;
  logic [31:0] reg_wdata_i = '0;
  logic [31:0] reg_rdata_o;
  logic [31:0] irq_o;
  logic        irq_active_o;

  urv_irq_controller #(.N_SRC(N_SRC), .SYNC_STAGES(SYNC_STAGES)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .irq_src_i    (irq_src_i),
    .reg_sel_i    (reg_sel_i),
    .reg_we_i     (reg_we_i),
    .reg_re_i     (reg_re_i),
    .reg_wdata_i  (reg_wdata_i),
    .reg_rdata_o  (reg_rdata_o),
    .irq_o        (irq_o),
    .irq_active_o (irq_active_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: source history, register images, and a service phase
  // (0 = nothing outstanding, 1 = presented, 2 = claimed)
  bit [31:0] hist[$];
  bit [31:0] m_en, m_edg, m_pend, m_irq, m_rdata;
  bit        m_active;
  int        m_phase, m_cur;

  function automatic int lowest_set(input bit [31:0] v);
    for (int i = 0; i < 32; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_en = '0; m_edg = '0; m_pend = '0; m_irq = '0; m_rdata = '0;
    m_active = 1'b0; m_phase = 0; m_cur = 0;
    hist.delete();
    for (int i = 0; i <= int'(SYNC_STAGES); i++) hist.push_back('0);
  endtask

  task automatic model_step();
    bit [31:0] now_lvl, before_lvl, view, cand, rise, clr;
    bit        live;
    now_lvl    = hist[SYNC_STAGES-1];
    before_lvl = hist[SYNC_STAGES];
    view = (m_edg & m_pend) | (~m_edg & now_lvl);
    cand = view & m_en;
    rise = now_lvl & ~before_lvl & m_edg;
    clr  = '0;
    live = (m_phase == 1) && cand[m_cur];
    if (reg_re_i) begin
      case (reg_sel_i)
        3'd0: m_rdata = m_en;
        3'd1: m_rdata = m_edg;
        3'd2: m_rdata = view;
        3'd3: m_rdata = live ? 32'(m_cur + 1) : 32'd0;
        default: m_rdata = '0;
      endcase
    end
    if (m_phase == 0) begin
      if (cand != 0) begin
        m_cur = lowest_set(cand);
        m_phase = 1;
        m_irq = 32'd1 << m_cur;
      end
    end else if (m_phase == 1) begin
      if (!cand[m_cur]) begin
        m_phase = 0;
        m_irq = '0;
      end else if (reg_re_i && reg_sel_i == 3'd3) begin
        m_phase = 2;
        m_irq = '0;
        clr = clr | ((32'd1 << m_cur) & m_edg);
      end
    end else begin
      if (reg_we_i && reg_sel_i == 3'd4 && reg_wdata_i[5:0] == 6'(m_cur + 1)) m_phase = 0;
    end
    if (reg_we_i) begin
      case (reg_sel_i)
        3'd0: m_en = reg_wdata_i;
        3'd1: m_edg = reg_wdata_i;
        3'd2: clr = clr | reg_wdata_i;
        default: ;
      endcase
    end
    m_pend = (m_pend & ~clr) | rise;
    m_active = (m_phase != 0);
    hist.push_front(irq_src_i);
    void'(hist.pop_back());
  endtask

  task automatic cyc();
    @(posedge clk_i);
    model_step();
    #1;
    check_val("irq_o", irq_o, m_irq);
    check_val("irq_active_o", 32'(irq_active_o), 32'(m_active));
    check_val("reg_rdata_o", reg_rdata_o, m_rdata);
  endtask

  task automatic wr(input logic [2:0] sel, input logic [31:0] data);
    reg_we_i = 1'b1; reg_sel_i = sel; reg_wdata_i = data;
    cyc();
    reg_we_i = 1'b0;
  endtask

  task automatic rd(input logic [2:0] sel);
    reg_re_i = 1'b1; reg_sel_i = sel;
    cyc();
    reg_re_i = 1'b0;
  endtask

  task automatic wait_irq(input int budget);
    int k;
    k = 0;
    while (irq_o == 0 && k < budget) begin
      cyc();
      k++;
    end
    if (irq_o == 0) check_val("wait_irq_timeout", irq_o, 32'hFFFF_FFFF);
  endtask

  initial begin
    logic [2:0] sel;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    check_val("rst_irq", irq_o, 32'h0);
    check_val("rst_active", 32'(irq_active_o), 32'h0);
    check_val("rst_rdata", reg_rdata_o, 32'h0);
    rst_i = 1'b1;

    // Edge source 3, single-cycle pulse
    wr(3'd1, 32'h8);
    wr(3'd0, 32'h8);
    irq_src_i = 32'h8;
    cyc();
    irq_src_i = 32'h0;
    repeat (SYNC_STAGES + 1) cyc();
    check_val("t1_irq", irq_o, 32'h8);
    rd(3'd3);
    check_val("t1_claim", reg_rdata_o, 32'd4);
    check_val("t1_irq_after_claim", irq_o, 32'h0);
    rd(3'd2);
    check_val("t1_pend3", reg_rdata_o & 32'h8, 32'h0);
    wr(3'd4, 32'd9);
    check_val("t1_bad_complete", 32'(irq_active_o), 32'h1);
    rd(3'd3);
    check_val("t1_second_claim", reg_rdata_o, 32'd0);
    wr(3'd4, 32'd4);
    check_val("t1_complete", 32'(irq_active_o), 32'h0);

    // Level sources 5 and 2 held together
    wr(3'd1, 32'h0);
    wr(3'd0, 32'h24);
    irq_src_i = 32'h24;
    wait_irq(20);
    check_val("t2_irq", irq_o, 32'h4);
    rd(3'd3);
    check_val("t2_claim", reg_rdata_o, 32'd3);
    wr(3'd4, 32'd3);
    check_val("t2_gap", irq_o, 32'h0);
    cyc();
    check_val("t2_rearm", irq_o, 32'h4);
    irq_src_i = 32'h0;
    wr(3'd0, 32'h0);
    repeat (3) cyc();
    check_val("t2_drop", irq_o, 32'h0);

    // Level source 7 drops before claim
    wr(3'd0, 32'h80);
    irq_src_i = 32'h80;
    wait_irq(20);
    check_val("t3_irq", irq_o, 32'h80);
    irq_src_i = 32'h0;
    repeat (SYNC_STAGES + 1) cyc();
    check_val("t3_drop", irq_o, 32'h0);
    rd(3'd3);
    check_val("t3_claim_idle", reg_rdata_o, 32'd0);

    // Source 1 pending while masked
    wr(3'd0, 32'h0);
    wr(3'd1, 32'h2);
    irq_src_i = 32'h2;
    cyc();
    irq_src_i = 32'h0;
    repeat (5) cyc();
    check_val("t5_masked", irq_o, 32'h0);
    rd(3'd2);
    check_val("t5_pending", reg_rdata_o, 32'h2);
    wr(3'd0, 32'h2);
    cyc();
    check_val("t5_unmask", irq_o, 32'h2);
    rd(3'd3);
    check_val("t5_claim", reg_rdata_o, 32'd2);

    // Asynchronous reset while in SERVICE
    #2;
    rst_i = 1'b0;
    irq_src_i = 32'h2;
    #1;
    check_val("t6_rst_irq", irq_o, 32'h0);
    check_val("t6_rst_active", 32'(irq_active_o), 32'h0);
    check_val("t6_rst_rdata", reg_rdata_o, 32'h0);
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_i = 1'b1;
    repeat (4) cyc();
    wr(3'd1, 32'h2);
    wr(3'd0, 32'h2);
    repeat (4) cyc();
    check_val("t6_no_edge", irq_o, 32'h0);
    irq_src_i = 32'h0;
    repeat (3) cyc();
    irq_src_i = 32'h2;
    wait_irq(20);
    check_val("t6_new_edge", irq_o, 32'h2);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(5) == 0) begin
        if ($urandom_range(9) == 0) irq_src_i = irq_src_i ^ (32'd1 << $urandom_range(31));
        else irq_src_i = irq_src_i ^ (32'd1 << $urandom_range(7));
      end
      case ($urandom_range(9))
        8: sel = 3'd3;
        9: sel = 3'd4;
        default: sel = 3'($urandom_range(7));
      endcase
      reg_sel_i   = sel;
      reg_re_i    = ($urandom_range(3) == 0);
      reg_we_i    = ($urandom_range(4) == 0);
      reg_wdata_i = $urandom;
      if (sel == 3'd0 && $urandom_range(1) == 0) reg_wdata_i = reg_wdata_i | 32'hFF;
      if (sel == 3'd4 && $urandom_range(1) == 0) reg_wdata_i = 32'(m_cur + 1);
      cyc();
    end
    reg_we_i = 1'b0;
    reg_re_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/urv_irq_controller.md
Name: urv_irq_controller

Overview:
- External interrupt controller in front of the exception unit's 32-bit IRQ input.
- Collects up to N_SRC asynchronous interrupt sources, latches them as pending and masks them.
- Picks one winner by fixed priority (lowest index wins) and presents it as a one-hot vector.
- Software claims and completes the interrupt through a small register port. Only one interrupt is outstanding at a time.

Parameters:
- N_SRC, 32: number of interrupt sources; legal range 1..32.
- SYNC_STAGES, 2: depth of the input synchronizer; minimum 2.

Ports:
- clk_i  in  1  core clock.
- rst_i  in  1  reset; asynchronous, active-low.
- irq_src_i  in  N_SRC  raw interrupt sources, asynchronous to clk_i.
- reg_sel_i  in  3  register select: 0 ENABLE, 1 EDGE, 2 PENDING, 3 CLAIM, 4 COMPLETE.
- reg_we_i  in  1  write strobe, one cycle.
- reg_re_i  in  1  read strobe, one cycle.
- reg_wdata_i  in  32  write data.
- reg_rdata_o  out  32  read data, registered.
- irq_o  out  32  one-hot selected source; feeds the exception unit IRQ vector. Bits at and above N_SRC are always 0.
- irq_active_o  out  1  a source is presented or being serviced (FSM is in PEND or SERVICE).

Behaviour:
- Reset values: all registers, synchronizer flops, irq_o, reg_rdata_o and irq_active_o are 0; FSM is IDLE.
- Synchronizer:
  - Each source passes through SYNC_STAGES flops, giving sync[i].
  - A rising edge is sync[i] high with the previous sync[i] low.
- ENABLE (RW, N_SRC bits): per-source mask.
- EDGE (RW): 1 = rising-edge triggered, 0 = level triggered.
- PENDING:
  - Edge source: the bit sets on a rising edge and clears on claim of that source or on a PENDING write with bit = 1 (write-1-to-clear).
  - Level source: the bit reads the current sync[i]; writes are ignored.
  - If a set and a clear of the same bit land in the same cycle, the set wins.
- Candidate vector: PENDING & ENABLE. The winner is the lowest set index.
- FSM:
  - IDLE: if any candidate exists, latch the winner id into cur_id and go to PEND. irq_o = one-hot(cur_id) from the next cycle.
  - PEND:
    - irq_o is held stable.
    - If the cur_id candidate bit drops (enable cleared, or a level source deasserts) before claim, go to IDLE and drop irq_o in the same cycle. No re-arbitration occurs in that cycle.
    - A higher-priority arrival does not preempt cur_id.
    - On a CLAIM read, go to SERVICE. reg_rdata_o = cur_id+1 on the next cycle. Clear the cur_id PENDING bit if it is an edge source.
  - SERVICE:
    - irq_o = 0; irq_active_o stays 1.
    - A COMPLETE write with reg_wdata_i[5:0] == cur_id+1 goes to IDLE.
    - A COMPLETE write with a non-matching value is ignored.
    - A CLAIM read in this state returns 0.
  - Arbitration resumes in the cycle after the return to IDLE, so at least 1 cycle of irq_o = 0 separates consecutive interrupts.
- CLAIM read in IDLE returns 0 with no side effect.
- Register reads: latency 1 cycle. reg_rdata_o holds its value until the next reg_re_i. Reads of unused selects (5..7) return 0.
- Writes to read-only or unused selects are ignored.
- If reg_we_i and reg_re_i are both asserted, both take effect.

Test Plan:
- Edge source 3 enabled, 1-cycle pulse on irq_src_i[3]:
  - irq_o = 32'h8 after SYNC_STAGES+2 cycles.
  - CLAIM read returns 4; PENDING[3] = 0; irq_o = 0.
  - COMPLETE write of 4 puts the FSM in IDLE; irq_active_o = 0.
- Level sources 5 and 2 enabled and held high together:
  - irq_o = 32'h4 and CLAIM returns 3.
  - After COMPLETE of 3, with both still high: irq_o = 32'h4 again after 1 idle cycle.
- Level source 7 in PEND, drops before claim: irq_o clears; a subsequent CLAIM read returns 0.
- In SERVICE with cur_id = 3:
  - COMPLETE write of 9 is ignored; the FSM stays in SERVICE.
  - A second CLAIM read returns 0.
- Source 1 pending but ENABLE = 0: irq_o stays 0. Setting ENABLE[1] raises irq_o = 32'h2 within 2 cycles.
- rst_i asserted low while in SERVICE: all outputs go to 0 immediately. After release, a new edge is required before any interrupt is presented.
